// File: rtl/xsleenacore_video_out_if.sv
// Video output stage bundle.
// Mixer-side inputs: HCLKn (pixel enable), VIDEO_R/G/B (4-bit colour),
// HSYNCn/VSYNCn/HBLKn/VBLKn (raw active-low timing), H_ADJ (signed HSYNC offset).
// Framework-side outputs: R/G/B_OUT (8-bit colour), HSYNC/VSYNC/HBLANK/VBLANK
// (active-high aligned timing), CE_PIXEL, LINE_PIXELS, FRAME_LINES, LOCKED.
// The slave modport is the video output stage; master is whatever drives it.
interface xsleenacore_video_out_if;
  logic       HCLKn;
  logic [3:0] VIDEO_R;
  logic [3:0] VIDEO_G;
  logic [3:0] VIDEO_B;
  logic       HSYNCn;
  logic       VSYNCn;
  logic       HBLKn;
  logic       VBLKn;
  logic [3:0] H_ADJ;
  logic [7:0] R_OUT;
  logic [7:0] G_OUT;
  logic [7:0] B_OUT;
  logic       HSYNC;
  logic       VSYNC;
  logic       HBLANK;
  logic       VBLANK;
  logic       CE_PIXEL;
  logic [8:0] LINE_PIXELS;
  logic [8:0] FRAME_LINES;
  logic       LOCKED;

  modport slave (
    input  HCLKn, VIDEO_R, VIDEO_G, VIDEO_B, HSYNCn, VSYNCn, HBLKn, VBLKn, H_ADJ,
    output R_OUT, G_OUT, B_OUT, HSYNC, VSYNC, HBLANK, VBLANK, CE_PIXEL,
           LINE_PIXELS, FRAME_LINES, LOCKED
  );

  modport master (
    output HCLKn, VIDEO_R, VIDEO_G, VIDEO_B, HSYNCn, VSYNCn, HBLKn, VBLKn, H_ADJ,
    input  R_OUT, G_OUT, B_OUT, HSYNC, VSYNC, HBLANK, VBLANK, CE_PIXEL,
           LINE_PIXELS, FRAME_LINES, LOCKED
  );
endinterface

// File: rtl/xsleenacore_video_out.sv
// Final video output stage: aligns mixer colour with timing-generator syncs
// and blanks in pixel-enable time, expands colour to 8 bits, applies a
// per-frame HSYNC offset and measures line/frame geometry with a lock flag.
// Ports: clk, rst (async, active-high), video (slave side of the bundle).
//
// Lock FSM states:
//   state        | meaning
//   ST_UNLOCKED  | no reference yet; next capture becomes the reference
//   ST_CHECK     | reference held; waiting for a matching capture
//   ST_LOCKED    | geometry stable; any mismatch drops lock
module xsleenacore_video_out #(
  parameter int SYNC_DELAY = 2
) (
  input logic clk,
  input logic rst,
  xsleenacore_video_out_if.slave video
);

  localparam int VDLY = 8;
  // The output register is the last stage of each path, so the internal
  // chains are one stage shorter than the total latency.
  localparam int VSR  = VDLY - 1;
  localparam int BSR  = SYNC_DELAY + VDLY - 1;

  typedef enum logic [1:0] {ST_UNLOCKED, ST_CHECK, ST_LOCKED} state_t;

  logic [11:0]       vid_sr [VSR];
  logic [2:0]        bv_sr  [BSR];   // {VSYNCn, HBLKn, VBLKn}
  logic [23:0]       hs_sr;
  logic [24:0]       hs_ext;
  logic [5:0]        hs_dly;
  logic [4:0]        hs_tap;
  logic signed [3:0] h_adj_eff;
  logic              blank_pre;
  logic [11:0]       vid_last;

  logic              hs_prev, vs_prev;
  logic              hs_fall, vs_fall;
  logic [8:0]        pix_cnt, line_cnt;
  logic [8:0]        lc_next, lp_next;
  logic [8:0]        ref_pix, ref_lines;
  logic              cap_match, ref_load;
  state_t            state, state_next;

  // HSYNC tap: total delay SYNC_DELAY+8+H_ADJ_eff, with the output register
  // counted as one stage. Index 0 of hs_ext is the undelayed input, so a
  // zero total delay collapses to a single register rather than a
  // combinational path.
  always_comb begin
    hs_ext    = {hs_sr, video.HSYNCn};
    hs_dly    = 6'(SYNC_DELAY + VDLY) + {{2{h_adj_eff[3]}}, h_adj_eff};
    hs_tap    = (hs_dly == 6'd0) ? 5'd0 : 5'(hs_dly - 6'd1);
    blank_pre = ~bv_sr[BSR-1][1] | ~bv_sr[BSR-1][0];
    vid_last  = vid_sr[VSR-1];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < VSR; i++) vid_sr[i] <= '0;
      for (int i = 0; i < BSR; i++) bv_sr[i] <= 3'b100;
      hs_sr          <= '1;
      h_adj_eff      <= '0;
      video.R_OUT    <= '0;
      video.G_OUT    <= '0;
      video.B_OUT    <= '0;
      video.HSYNC    <= 1'b0;
      video.VSYNC    <= 1'b0;
      video.HBLANK   <= 1'b1;
      video.VBLANK   <= 1'b1;
      video.CE_PIXEL <= 1'b0;
    end else begin
      video.CE_PIXEL <= video.HCLKn;
      if (video.HCLKn) begin
        vid_sr[0] <= {video.VIDEO_R, video.VIDEO_G, video.VIDEO_B};
        for (int i = 1; i < VSR; i++) vid_sr[i] <= vid_sr[i-1];
        bv_sr[0] <= {video.VSYNCn, video.HBLKn, video.VBLKn};
        for (int i = 1; i < BSR; i++) bv_sr[i] <= bv_sr[i-1];
        hs_sr <= {hs_sr[22:0], video.HSYNCn};
        // New offset takes effect only at frame start.
        if (vs_fall) h_adj_eff <= signed'(video.H_ADJ);

        video.HSYNC  <= ~hs_ext[hs_tap];
        video.VSYNC  <= ~bv_sr[BSR-1][2];
        video.HBLANK <= ~bv_sr[BSR-1][1];
        video.VBLANK <= ~bv_sr[BSR-1][0];
        if (blank_pre) begin
          video.R_OUT <= '0;
          video.G_OUT <= '0;
          video.B_OUT <= '0;
        end else begin
          video.R_OUT <= {vid_last[11:8], vid_last[11:8]};
          video.G_OUT <= {vid_last[7:4], vid_last[7:4]};
          video.B_OUT <= {vid_last[3:0], vid_last[3:0]};
        end
      end
    end
  end

  // Geometry measurement on raw inputs. A line increment coinciding with a
  // VSYNC fall is folded into the captured frame length.
  always_comb begin
    hs_fall   = hs_prev & ~video.HSYNCn;
    vs_fall   = vs_prev & ~video.VSYNCn;
    lc_next   = line_cnt;
    if (hs_fall && line_cnt != 9'd511) lc_next = line_cnt + 9'd1;
    lp_next   = hs_fall ? pix_cnt : video.LINE_PIXELS;
    cap_match = (lp_next != 9'd511) && (lc_next != 9'd511) &&
                (lp_next == ref_pix) && (lc_next == ref_lines);
  end

  always_comb begin
    state_next = state;
    ref_load   = 1'b0;
    if (video.HCLKn && vs_fall) begin
      case (state)
        ST_UNLOCKED: begin
          ref_load   = 1'b1;
          state_next = ST_CHECK;
        end
        ST_CHECK: begin
          if (cap_match) state_next = ST_LOCKED;
          else           ref_load   = 1'b1;
        end
        ST_LOCKED: begin
          if (!cap_match) state_next = ST_UNLOCKED;
        end
        default: state_next = ST_UNLOCKED;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state             <= ST_UNLOCKED;
      video.LOCKED      <= 1'b0;
      hs_prev           <= 1'b1;
      vs_prev           <= 1'b1;
      pix_cnt           <= '0;
      line_cnt          <= '0;
      ref_pix           <= '0;
      ref_lines         <= '0;
      video.LINE_PIXELS <= '0;
      video.FRAME_LINES <= '0;
    end else begin
      state        <= state_next;
      video.LOCKED <= (state_next == ST_LOCKED);
      if (ref_load) begin
        ref_pix   <= lp_next;
        ref_lines <= lc_next;
      end
      if (video.HCLKn) begin
        hs_prev <= video.HSYNCn;
        vs_prev <= video.VSYNCn;
        if (hs_fall) begin
          video.LINE_PIXELS <= pix_cnt;
          pix_cnt           <= 9'd1;
        end else if (pix_cnt != 9'd511) begin
          pix_cnt <= pix_cnt + 9'd1;
        end
        if (vs_fall) begin
          video.FRAME_LINES <= lc_next;
          line_cnt          <= '0;
        end else begin
          line_cnt <= lc_next;
        end
      end
    end
  end

endmodule
